dm_byte_ctrl: RTL

Parametrised data memory for the pipelined MIPS core, successor to the word-only DM. Adds byte/halfword loads and stores with sign or zero extension, a configurable access latency behind a req/ready handshake that the MEM stage stalls on, and address-error detection (AdEL/AdES) for the exception unit. Sits in the MEM stage between the ALU result/rt forwarding muxes and the W-stage pipeline register.

---
 rtl/dm_byte_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dm_byte_ctrl.sv
// Data memory for the MIPS MEM stage: byte/half/word loads and stores, fixed latency behind req/ready,
// AdEL/AdES detection. Defining DM_TRACE_EN prints one line per committed store.
module dm_byte_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        exc_adel,
   output logic        exc_ades
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   state_t      state, stateNext;
   logic [3:0]  count;
   logic        accept, enterResp;
   logic        weQ;
   logic [2:0]  opQ;
   logic [31:0] addrQ, wdataQ;
   logic        curWe;
   logic [2:0]  curOp;
   logic [31:0] curAddr, curWdata;
   logic        accErr;
   logic [ADDR_W-1:0] wordIdx;
   logic [31:0] oldWord, newWord, storeData, loadData, byteWord;
   logic [15:0] halfSel;
   logic [7:0]  byteSel;
   logic [3:0]  laneEn;
   logic [31:0] mem [DEPTH];

   // The counter reaches zero on the same edge that enters RESP, giving ready LATENCY cycles after accept
   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      case (state)
         IDLE, RESP: begin
            stateNext = IDLE;
            if (req) begin
               accept    = 1'b1;
               stateNext = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT:    if (count == 4'd1) stateNext = RESP;
         default: stateNext = IDLE;
      endcase
      enterResp = (stateNext == RESP);
   end

   // With LATENCY=1 the access happens on the accept edge, so it must use the live inputs
   assign curWe    = (state == WAIT) ? weQ    : we;
   assign curOp    = (state == WAIT) ? opQ    : op;
   assign curAddr  = (state == WAIT) ? addrQ  : addr;
   assign curWdata = (state == WAIT) ? wdataQ : wdata;
   assign wordIdx  = curAddr[ADDR_W+1:2];
   assign oldWord  = mem[wordIdx];

   always_comb begin
      accErr = 1'b0;
      case (curOp)
         3'b000:  accErr = (curAddr[1:0] != 2'b00);
         3'b001:  accErr = curAddr[0];
         3'b010:  accErr = curAddr[0] | curWe;
         3'b011:  accErr = 1'b0;
         3'b100:  accErr = curWe;
         default: accErr = 1'b1;
      endcase
      if ((curAddr >> (ADDR_W + 2)) != 32'd0) accErr = 1'b1;
   end

   always_comb begin
      laneEn    = 4'b0000;
      storeData = curWdata;
      case (curOp)
         3'b000: laneEn = 4'b1111;
         3'b001, 3'b010: begin
            laneEn    = curAddr[1] ? 4'b1100 : 4'b0011;
            storeData = {2{curWdata[15:0]}};
         end
         3'b011, 3'b100: begin
            laneEn    = 4'b0001 << curAddr[1:0];
            storeData = {4{curWdata[7:0]}};
         end
         default: laneEn = 4'b0000;
      endcase
      for (int i = 0; i < 4; i++)
         newWord[8*i +: 8] = laneEn[i] ? storeData[8*i +: 8] : oldWord[8*i +: 8];
   end

   assign byteWord = oldWord >> {curAddr[1:0], 3'b000};
   assign byteSel  = byteWord[7:0];
   assign halfSel  = curAddr[1] ? oldWord[31:16] : oldWord[15:0];

   always_comb begin
      case (curOp)
         3'b000:  loadData = oldWord;
         3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
         3'b010:  loadData = {16'h0000, halfSel};
         3'b011:  loadData = {{24{byteSel[7]}}, byteSel};
         3'b100:  loadData = {24'h000000, byteSel};
         default: loadData = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 4'd0;
         rdata    <= 32'h0;
         exc_adel <= 1'b0;
         exc_ades <= 1'b0;
         weQ      <= 1'b0;
         opQ      <= 3'b000;
         addrQ    <= 32'h0;
         wdataQ   <= 32'h0;
      end else begin
         state <= stateNext;
         if (accept) begin
            weQ    <= we;
            opQ    <= op;
            addrQ  <= addr;
            wdataQ <= wdata;
            count  <= LAT_LOAD;
         end else if (state == WAIT) begin
            count <= count - 4'd1;
         end
         if (enterResp) begin
            rdata    <= (curWe || accErr) ? 32'h0 : loadData;
            exc_adel <= accErr && !curWe;
            exc_ades <= accErr && curWe;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else if (enterResp && curWe && !accErr) begin
         mem[wordIdx] <= newWord;
      end
   end

   assign ready = (state == RESP);
   assign busy  = (state == WAIT);

`ifdef DM_TRACE_EN
   logic [31:0] pcQ, curPc;

   always_ff @(posedge clk) begin
      if (reset)       pcQ <= 32'h0;
      else if (accept) pcQ <= pc;
   end

   assign curPc = (state == WAIT) ? pcQ : pc;

   always_ff @(posedge clk) begin
      if (!reset && enterResp && curWe && !accErr)
         $display("@%h: *%h <= %h", curPc, {curAddr[31:2], 2'b00}, newWord);
   end
`else
   logic unusedPc;
   assign unusedPc = ^pc;
`endif

endmodule
